// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential packed-BCD adder/subtractor.
// Digit validity helper is used on the accept edge to build the error flag.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single decimal digit adder: x + y + c with the classic +6 correction above nine.
// Out-of-range inputs still produce a defined (mod 16) digit.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_c,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [4:0] w_sum;

    assign w_sum = {1'b0, i_x} + {1'b0, i_y} + {4'b0000, i_c};

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        o_digit = w_sum[3:0];
        o_carry = 1'b0;
        if (w_sum > {1'b0, BCD_MAX}) begin
            o_digit = w_sum[3:0] + BCD_ADJ;
            o_carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock, least significant digit first.
// Subtraction adds the nines' complement of B with an inverted borrow as the initial carry.
module bcd_addsub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] result,
    output logic                cout,
    output logic                err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic                r_sub;
    logic                r_carry;
    logic [4*DIGITS-1:0] r_result;
    logic                r_cout;
    logic                r_err;
    logic                r_out_valid;

    logic [3:0]          w_a_dig;
    logic [3:0]          w_b_dig;
    logic [3:0]          w_y;
    logic [3:0]          w_digit;
    logic                w_carry;
    logic                w_in_err;

    // Current digit of each latched operand, selected by the index counter.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_a_dig = r_a[4*d +: 4];
                w_b_dig = r_b[4*d +: 4];
            end
        end
    end

    assign w_y = r_sub ? (BCD_MAX - w_b_dig) : w_b_dig;

    bcd_digit_adder u_digit_adder (
        .i_x     (w_a_dig),
        .i_y     (w_y),
        .i_c     (r_carry),
        .o_digit (w_digit),
        .o_carry (w_carry)
    );

    always_comb begin
        w_in_err = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (!is_bcd(a[4*d +: 4]) || !is_bcd(b[4*d +: 4])) begin
                w_in_err = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: operand registers are reset too; cheap here and keeps the datapath free of X.
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_sub    <= sub;
                        r_carry  <= sub ? ~cin : cin;
                        r_err    <= w_in_err;
                        r_result <= '0;
                        r_idx    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    for (int d = 0; d < DIGITS; d++) begin
                        if (r_idx == IDX_W'(d)) begin
                            r_result[4*d +: 4] <= w_digit;
                        end
                    end
                    r_carry <= w_carry;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_carry;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed-vector bench for bcd_addsub_seq with DIGITS=4 and hand-computed BCD results.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_bcd_addsub_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands until the accept edge, then drop in_valid.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv, input string tag);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, DIGITS);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv, input bit chk_res,
                          input logic [W-1:0] exp_res, input logic exp_cout,
                          input logic exp_err, input string tag);
        start_op(av, bv, cv, sv, tag);
        wait_done(tag);
        if (chk_res) begin
            check({tag, ".result"}, {16'b0, result}, {16'b0, exp_res});
            check({tag, ".cout"}, {31'b0, cout}, {31'b0, exp_cout});
        end
        check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
        handshake(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        tick();
        tick();
        check("reset.out_valid", {31'b0, out_valid}, 32'd0);
        check("reset.in_ready", {31'b0, in_ready}, 32'd1);
        check("reset.result", {16'b0, result}, 32'h0);
        check("reset.cout", {31'b0, cout}, 32'd0);
        check("reset.err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Additions, including full carry ripple and carry-in.
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, "add_1234_5678");
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "add_9999_0001");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, "add_cin");

        // Subtractions: no borrow, borrow (ten's complement), borrow-in.
        run_op(16'h5000, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0, "sub_5000_1234");
        run_op(16'h1234, 16'h5000, 1'b0, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0, "sub_1234_5000");
        run_op(16'h0042, 16'h0042, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, "sub_bin");

        // Invalid nibble flags err; a following valid op clears it.
        run_op(16'h00C0, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, "err_set");
        run_op(16'h0005, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, "err_clear");

        // Back-pressure in DONE: new operands offered but ignored.
        start_op(16'h0001, 16'h0002, 1'b0, 1'b0, "hold");
        wait_done("hold");
        a        = 16'h9999;
        b        = 16'h9999;
        sub      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("hold.result", {16'b0, result}, 32'h0003);
            check("hold.out_valid", {31'b0, out_valid}, 32'd1);
            check("hold.in_ready", {31'b0, in_ready}, 32'd0);
        end
        check("hold.cout", {31'b0, cout}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold.hs_out_valid", {31'b0, out_valid}, 32'd0);
        check("hold.hs_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
        check("hold.accepted", {31'b0, in_ready}, 32'd0);
        wait_done("hold2");
        check("hold2.result", {16'b0, result}, 32'h0000);
        check("hold2.cout", {31'b0, cout}, 32'd1);
        handshake("hold2");

        // Reset in the middle of RUN aborts the operation.
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0, "abort");
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort.out_valid", {31'b0, out_valid}, 32'd0);
        check("abort.in_ready", {31'b0, in_ready}, 32'd1);
        check("abort.result", {16'b0, result}, 32'h0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
